// File: rtl/tdc_result_reader_if.sv
// TDC parallel-bus signals used on the read side.
// The reader is the master; the TDC (or its model) is the slave.
interface tdc_result_reader_if;
   logic [3:0]  addr;
   logic        csn;
   logic        rdn;
   logic [27:0] din;
   logic        intn;

   modport master (
      output addr,
      output csn,
      output rdn,
      input  din,
      input  intn
   );

   modport slave (
      input  addr,
      input  csn,
      input  rdn,
      output din,
      output intn
   );
endinterface

// File: rtl/tdc_result_reader.sv
// Reads a window of TDC result registers after each INTN falling edge.
// Each captured word is presented with a one-cycle valid pulse; late interrupts are flagged.
module tdc_result_reader #(
   parameter int unsigned FIRST_ADDR = 8,
   parameter int unsigned NUM_REGS   = 3,
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        cfg_busy_i,
   input  logic                        clr_overrun_i,
   tdc_result_reader_if.master         tdc_bus_io,
   output logic [27:0]                 result_data_o,
   output logic [3:0]                  result_addr_o,
   output logic                        result_valid_o,
   output logic                        frame_done_o,
   output logic                        busy_o,
   output logic                        overrun_o
);

   typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

   localparam logic [3:0] FirstAddr  = 4'(FIRST_ADDR);
   localparam logic [3:0] SetupLast  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] StrobeLast = 4'(STROBE_CYC - 1);
   localparam logic [2:0] IdxLast    = 3'(NUM_REGS - 1);

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        intn_meta_q, intn_sync_q, intn_prev_q;
   logic        intn_fall;

   logic [3:0]  addr_q, addr_d;
   logic        strobe_n_q, strobe_n_d;
   logic [27:0] result_data_q, result_data_d;
   logic [3:0]  result_addr_q, result_addr_d;
   logic        result_valid_q, result_valid_d;
   logic        frame_done_q, frame_done_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
   logic        leave_strobe;

   assign intn_fall = intn_prev_q & ~intn_sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         cnt_q          <= '0;
         intn_meta_q    <= 1'b1;
         intn_sync_q    <= 1'b1;
         intn_prev_q    <= 1'b1;
         addr_q         <= 4'hf;
         strobe_n_q     <= 1'b1;
         result_data_q  <= '0;
         result_addr_q  <= '0;
         result_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         busy_q         <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         intn_meta_q    <= tdc_bus_io.intn;
         intn_sync_q    <= intn_meta_q;
         intn_prev_q    <= intn_sync_q;
         addr_q         <= addr_d;
         strobe_n_q     <= strobe_n_d;
         result_data_q  <= result_data_d;
         result_addr_q  <= result_addr_d;
         result_valid_q <= result_valid_d;
         frame_done_q   <= frame_done_d;
         busy_q         <= busy_d;
         overrun_q      <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (intn_fall && !cfg_busy_i) begin
               state_d = StSetup;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         StSetup: begin
            if (cnt_q == SetupLast) begin
               state_d = StStrobe;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StStrobe: begin
            if (cnt_q == StrobeLast) begin
               state_d = StHold;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StHold: begin
            if (idx_q == IdxLast) begin
               state_d = StDone;
            end else begin
               state_d = StSetup;
               idx_d   = idx_q + 3'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      addr_d = 4'hf;
      if (state_d inside {StSetup, StStrobe, StHold}) begin
         addr_d = FirstAddr + {1'b0, idx_d};
      end
      strobe_n_d     = (state_d != StStrobe);
      leave_strobe   = (state_q == StStrobe) && (state_d != StStrobe);
      result_valid_d = leave_strobe;
      result_data_d  = leave_strobe ? tdc_bus_io.din : result_data_q;
      result_addr_d  = leave_strobe ? addr_q : result_addr_q;
      frame_done_d   = (state_d == StDone);
      busy_d         = (state_d != StIdle);
      overrun_d      = overrun_q;
      if (intn_fall && busy_q) begin
         overrun_d = 1'b1;
      end else if (clr_overrun_i) begin
         overrun_d = 1'b0;
      end
   end

   assign tdc_bus_io.addr = addr_q;
   assign tdc_bus_io.csn  = strobe_n_q;
   assign tdc_bus_io.rdn  = strobe_n_q;
   assign result_data_o   = result_data_q;
   assign result_addr_o   = result_addr_q;
   assign result_valid_o  = result_valid_q;
   assign frame_done_o    = frame_done_q;
   assign busy_o          = busy_q;
   assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_tdc_result_reader.sv
// Directed bench for tdc_result_reader: default instance plus a second parameter set.
module tb_tdc_result_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, cfg_a, cfg_b, clr_a, clr_b;
   logic [27:0] rd_a, rd_b;
   logic [3:0]  ra_a, ra_b;
   logic        rv_a, rv_b, fd_a, fd_b, bz_a, bz_b, ov_a, ov_b;

   tdc_result_reader_if bus_a ();
   tdc_result_reader_if bus_b ();

   assign bus_a.din = 28'h0000100 + 28'(bus_a.addr);
   assign bus_b.din = 28'h0000100 + 28'(bus_b.addr);

   tdc_result_reader u_dut_a (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_busy_i     (cfg_a),
      .clr_overrun_i  (clr_a),
      .tdc_bus_io     (bus_a.master),
      .result_data_o  (rd_a),
      .result_addr_o  (ra_a),
      .result_valid_o (rv_a),
      .frame_done_o   (fd_a),
      .busy_o         (bz_a),
      .overrun_o      (ov_a)
   );

   tdc_result_reader #(
      .FIRST_ADDR (11),
      .NUM_REGS   (2),
      .SETUP_CYC  (3),
      .STROBE_CYC (1)
   ) u_dut_b (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_busy_i     (cfg_b),
      .clr_overrun_i  (clr_b),
      .tdc_bus_io     (bus_b.master),
      .result_data_o  (rd_b),
      .result_addr_o  (ra_b),
      .result_valid_o (rv_b),
      .frame_done_o   (fd_b),
      .busy_o         (bz_b),
      .overrun_o      (ov_b)
   );

   int vectors = 0;
   int miscompares = 0;

   int          n_valid, n_done, bcnt, done_at, run, pre, csn_mm;
   logic        prev_csn;
   logic [27:0] dq[$];
   logic [3:0]  aq[$];
   logic [3:0]  saddr_q[$];
   int          slen_q[$];
   int          setup_q[$];

   task automatic mon_clear();
      n_valid = 0; n_done = 0; bcnt = 0; done_at = -1; run = 0; pre = 0; csn_mm = 0;
      prev_csn = 1'b1;
      dq.delete(); aq.delete(); saddr_q.delete(); slen_q.delete(); setup_q.delete();
   endtask

   // Advance one cycle and record bus activity of the selected instance.
   task automatic tick(input bit b);
      logic c, r, v, d, bz;
      logic [3:0]  a, ra;
      logic [27:0] rd;
      @(negedge clk);
      c  = b ? bus_b.csn  : bus_a.csn;
      r  = b ? bus_b.rdn  : bus_a.rdn;
      a  = b ? bus_b.addr : bus_a.addr;
      v  = b ? rv_b : rv_a;
      d  = b ? fd_b : fd_a;
      bz = b ? bz_b : bz_a;
      rd = b ? rd_b : rd_a;
      ra = b ? ra_b : ra_a;
      if (c !== r) csn_mm++;
      if (c === 1'b0) begin
         if (run == 0) begin
            saddr_q.push_back(a);
            setup_q.push_back(pre);
            pre = 0;
         end
         run++;
      end else begin
         if (run > 0) begin
            slen_q.push_back(run);
            run = 0;
         end
         if (a === 4'hf) pre = 0;
         else if (prev_csn === 1'b1) pre++;
      end
      prev_csn = c;
      if (bz === 1'b1) bcnt++;
      if (d === 1'b1) begin
         n_done++;
         done_at = bcnt;
      end
      if (v === 1'b1) begin
         n_valid++;
         dq.push_back(rd);
         aq.push_back(ra);
      end
   endtask

   task automatic ticks(input bit b, input int n);
      for (int i = 0; i < n; i++) tick(b);
   endtask

   task automatic fire_a();
      bus_a.intn = 1'b0; ticks(0, 3); bus_a.intn = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ticks(0, 2);
      vectors++;
      if (bus_a.addr !== 4'hf) begin
         miscompares++; $display("FAIL reset_addr: got %h expected f", bus_a.addr);
      end
      vectors++;
      if (bus_a.csn !== 1'b1 || bus_a.rdn !== 1'b1) begin
         miscompares++; $display("FAIL reset_strobes: got csn=%b rdn=%b expected 1/1", bus_a.csn, bus_a.rdn);
      end
      vectors++;
      if ({rv_a, fd_a, bz_a, ov_a} !== 4'b0000) begin
         miscompares++; $display("FAIL reset_flags: got %b expected 0000", {rv_a, fd_a, bz_a, ov_a});
      end
      vectors++;
      if (rd_a !== 28'h0 || ra_a !== 4'h0) begin
         miscompares++; $display("FAIL reset_result: got %h/%h expected 0/0", rd_a, ra_a);
      end
      reset_n = 1'b1;
      ticks(0, 2);
   endtask

   task automatic test_basic_frame();
      logic [27:0] exp_d [3];
      logic [3:0]  exp_a [3];
      exp_d = '{28'h0000108, 28'h0000109, 28'h000010A};
      exp_a = '{4'd8, 4'd9, 4'd10};
      mon_clear();
      fire_a();
      ticks(0, 27);
      vectors++;
      if (n_valid != 3) begin
         miscompares++; $display("FAIL basic_valid_count: got %0d expected 3", n_valid);
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (i >= dq.size() || dq[i] !== exp_d[i] || aq[i] !== exp_a[i]) begin
            miscompares++;
            $display("FAIL basic_word%0d: got %h@%h expected %h@%h", i,
                     (i < dq.size()) ? dq[i] : 28'hx, (i < aq.size()) ? aq[i] : 4'hx,
                     exp_d[i], exp_a[i]);
         end
         vectors++;
         if (i >= saddr_q.size() || saddr_q[i] !== exp_a[i] || slen_q[i] != 2 || setup_q[i] != 1) begin
            miscompares++;
            $display("FAIL basic_strobe%0d: got addr=%h len=%0d setup=%0d expected %h/2/1", i,
                     (i < saddr_q.size()) ? saddr_q[i] : 4'hx,
                     (i < slen_q.size()) ? slen_q[i] : -1, (i < setup_q.size()) ? setup_q[i] : -1,
                     exp_a[i]);
         end
      end
      vectors++;
      if (n_done != 1 || done_at != 13) begin
         miscompares++; $display("FAIL basic_frame_done: got count=%0d at=%0d expected 1 at 13", n_done, done_at);
      end
      vectors++;
      if (bus_a.addr !== 4'hf || bz_a !== 1'b0 || csn_mm != 0) begin
         miscompares++;
         $display("FAIL basic_end: got addr=%h busy=%b csn_rdn_diff=%0d expected f/0/0", bus_a.addr, bz_a, csn_mm);
      end
   endtask

   task automatic test_cfg_busy();
      mon_clear();
      cfg_a = 1'b1;
      bus_a.intn = 1'b0; ticks(0, 4); bus_a.intn = 1'b1;
      ticks(0, 6);
      cfg_a = 1'b0;
      ticks(0, 20);
      vectors++;
      if (saddr_q.size() != 0 || n_valid != 0 || ov_a !== 1'b0) begin
         miscompares++;
         $display("FAIL cfg_discard: got strobes=%0d valid=%0d overrun=%b expected 0/0/0",
                  saddr_q.size(), n_valid, ov_a);
      end
      mon_clear();
      fire_a();
      ticks(0, 27);
      vectors++;
      if (n_valid != 3 || n_done != 1) begin
         miscompares++; $display("FAIL cfg_later_frame: got valid=%0d done=%0d expected 3/1", n_valid, n_done);
      end
   endtask

   task automatic test_overrun();
      int guard;
      mon_clear();
      fire_a();
      guard = 0;
      while (saddr_q.size() < 2 && guard < 30) begin
         tick(0);
         guard++;
      end
      vectors++;
      if (saddr_q.size() < 2) begin
         miscompares++; $display("FAIL ovr_reach_reg9: got strobes=%0d expected 2", saddr_q.size());
      end
      bus_a.intn = 1'b0;
      ticks(0, 40);
      bus_a.intn = 1'b1;
      ticks(0, 3);
      vectors++;
      if (n_valid != 3 || saddr_q.size() != 3 || n_done != 1) begin
         miscompares++;
         $display("FAIL ovr_single_frame: got valid=%0d strobes=%0d done=%0d expected 3/3/1",
                  n_valid, saddr_q.size(), n_done);
      end
      vectors++;
      if (dq.size() != 3 || dq[1] !== 28'h0000109) begin
         miscompares++; $display("FAIL ovr_data: got %h expected 0000109", (dq.size() > 1) ? dq[1] : 28'hx);
      end
      vectors++;
      if (ov_a !== 1'b1) begin
         miscompares++; $display("FAIL ovr_set: got %b expected 1", ov_a);
      end
      clr_a = 1'b1; tick(0); clr_a = 1'b0; tick(0);
      vectors++;
      if (ov_a !== 1'b0) begin
         miscompares++; $display("FAIL ovr_clear: got %b expected 0", ov_a);
      end
      // Second fall lands on the same edge as clr_overrun; the set must win.
      fire_a();
      ticks(0, 4);
      bus_a.intn = 1'b0; clr_a = 1'b1;
      ticks(0, 3);
      clr_a = 1'b0;
      vectors++;
      if (ov_a !== 1'b1) begin
         miscompares++; $display("FAIL ovr_set_wins: got %b expected 1", ov_a);
      end
      bus_a.intn = 1'b1;
      ticks(0, 20);
   endtask

   task automatic test_reset_mid();
      int guard;
      mon_clear();
      fire_a();
      guard = 0;
      while (!(bus_a.csn === 1'b0 && bus_a.addr === 4'd9) && guard < 30) begin
         tick(0);
         guard++;
      end
      vectors++;
      if (bus_a.csn !== 1'b0 || bus_a.addr !== 4'd9) begin
         miscompares++; $display("FAIL rmid_reach: got csn=%b addr=%h expected 0/9", bus_a.csn, bus_a.addr);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (bus_a.csn !== 1'b1 || bus_a.rdn !== 1'b1 || bus_a.addr !== 4'hf || bz_a !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_immediate: got csn=%b rdn=%b addr=%h busy=%b expected 1/1/f/0",
                  bus_a.csn, bus_a.rdn, bus_a.addr, bz_a);
      end
      mon_clear();
      ticks(0, 3);
      reset_n = 1'b1;
      ticks(0, 15);
      vectors++;
      if (n_valid != 0 || n_done != 0) begin
         miscompares++; $display("FAIL rmid_no_partial: got valid=%0d done=%0d expected 0/0", n_valid, n_done);
      end
      mon_clear();
      fire_a();
      ticks(0, 27);
      vectors++;
      if (n_valid != 3 || n_done != 1 || saddr_q.size() == 0 || saddr_q[0] !== 4'd8) begin
         miscompares++;
         $display("FAIL rmid_new_frame: got valid=%0d done=%0d first=%h expected 3/1/8",
                  n_valid, n_done, (saddr_q.size() > 0) ? saddr_q[0] : 4'hx);
      end
   endtask

   task automatic test_params();
      logic [27:0] exp_d [2];
      logic [3:0]  exp_a [2];
      exp_d = '{28'h000010B, 28'h000010C};
      exp_a = '{4'd11, 4'd12};
      mon_clear();
      bus_b.intn = 1'b0; ticks(1, 3); bus_b.intn = 1'b1;
      ticks(1, 27);
      vectors++;
      if (n_valid != 2) begin
         miscompares++; $display("FAIL param_valid_count: got %0d expected 2", n_valid);
      end
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (i >= dq.size() || dq[i] !== exp_d[i] || aq[i] !== exp_a[i]) begin
            miscompares++;
            $display("FAIL param_word%0d: got %h@%h expected %h@%h", i,
                     (i < dq.size()) ? dq[i] : 28'hx, (i < aq.size()) ? aq[i] : 4'hx,
                     exp_d[i], exp_a[i]);
         end
         vectors++;
         if (i >= saddr_q.size() || saddr_q[i] !== exp_a[i] || slen_q[i] != 1 || setup_q[i] != 3) begin
            miscompares++;
            $display("FAIL param_strobe%0d: got addr=%h len=%0d setup=%0d expected %h/1/3", i,
                     (i < saddr_q.size()) ? saddr_q[i] : 4'hx,
                     (i < slen_q.size()) ? slen_q[i] : -1, (i < setup_q.size()) ? setup_q[i] : -1,
                     exp_a[i]);
         end
      end
      vectors++;
      if (n_done != 1 || done_at != 11 || bus_b.addr !== 4'hf) begin
         miscompares++;
         $display("FAIL param_frame_done: got count=%0d at=%0d addr=%h expected 1 at 11, f",
                  n_done, done_at, bus_b.addr);
      end
   endtask

   task automatic test_held_low();
      mon_clear();
      bus_a.intn = 1'b0;
      ticks(0, 50);
      bus_a.intn = 1'b1;
      ticks(0, 5);
      vectors++;
      if (n_done != 1 || n_valid != 3) begin
         miscompares++; $display("FAIL held_single_frame: got done=%0d valid=%0d expected 1/3", n_done, n_valid);
      end
      vectors++;
      if (bz_a !== 1'b0) begin
         miscompares++; $display("FAIL held_busy_end: got %b expected 0", bz_a);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      cfg_a = 1'b0; cfg_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      bus_a.intn = 1'b1; bus_b.intn = 1'b1;
      mon_clear();
      test_reset();
      test_basic_frame();
      test_cfg_busy();
      test_overrun();
      test_reset_mid();
      test_params();
      test_held_low();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
